l1_l2_port_arbiter: RTL and testbench
=====================================

// Module: l1_l2_port_arbiter
// PURPOSE
// - Shares the single L1->L2 refill/writeback port between the IL1 miss path and the DL1 miss/writeback path.
// - Sits between the IL1/DL1 controllers and the L2 cache, and serialises one transaction at a time.
// - Blocks new grants while L2 back-invalidation (inclusive replacement) is in progress.
// - Provides round-robin fairness and a watchdog that flags a hung L2 transaction.
// PARAMETERS
// - ADDR_W     32   request address width (line-aligned; low LINE_OFF bits ignored)
// - LINE_OFF   4    byte+word offset bits; forced to 0 on l2_addr
// - TIMEOUT    255  max cycles from l2_ack to l2_done before l2_timeout fires (counter 8 bit)
// PORTS
// - clk_l1       in   1       L1 clock; all state updates on posedge
// - rst          in   1       synchronous reset, active-high
// - il1_req      in   1       IL1 refill request; level, held until il1_done
// - il1_addr     in   ADDR_W  IL1 miss address
// - il1_done     out  1       1-cycle pulse: IL1 transaction complete
// - dl1_req      in   1       DL1 request; level, held until dl1_done
// - dl1_we       in   1       1 = writeback, 0 = refill
// - dl1_addr     in   ADDR_W  DL1 address
// - dl1_done     out  1       1-cycle pulse: DL1 transaction complete
// - inv_busy     in   1       L2 back-invalidation active; no new grant while high
// - l2_req       out  1       request to L2; held until l2_ack
// - l2_we        out  1       write/read qualifier for l2_req
// - l2_addr      out  ADDR_W  line-aligned address for l2_req
// - l2_src       out  1       0 = IL1, 1 = DL1 owner of current transaction
// - l2_ack       in   1       L2 accepted request (sampled only in ISSUE)
// - l2_done      in   1       L2 finished transaction (sampled only in WAIT)
// - l2_timeout   out  1       sticky error; cleared only by rst
// BEHAVIOUR
// - Reset: state = IDLE, rr_last = DL1 (so IL1 wins first tie), all outputs 0, watchdog = 0.
// - FSM states: IDLE, ISSUE, WAIT, RESP.
// - IDLE: if inv_busy -> stay. Else pick a winner among the asserted requests.
//   - Tie: the winner is the requester not equal to rr_last.
//   - Latch src/addr/we; dl1_we is forced to 0 for IL1.
//   - Go to ISSUE on the next edge; this gives 1-cycle grant latency.
// - ISSUE: l2_req = 1 with latched addr/we/src, all stable. l2_ack = 1 -> WAIT, l2_req drops next cycle.
// - WAIT: l2_req = 0; the watchdog increments each cycle.
//   - l2_done = 1 -> RESP, watchdog cleared.
//   - Watchdog == TIMEOUT without l2_done -> set l2_timeout and stay in WAIT.
// - RESP: pulse il1_done or dl1_done (per l2_src) for exactly 1 cycle, set rr_last = src, -> IDLE.
//   - A requester must drop req in the cycle after done; a still-high req is treated as a new request.
// - Minimum transaction: IDLE -> ISSUE -> WAIT -> RESP = 4 cycles with l2_ack and l2_done each 1 cycle late.
// - Simultaneous l2_ack and l2_done in ISSUE: only the ack is honoured; done must be re-asserted in WAIT.
// - inv_busy rising in ISSUE/WAIT/RESP does not abort the transaction; it only gates the next IDLE grant.
// - A request dropped before grant is ignored. A request dropped after grant does not abort the transaction.
// - Address is not re-sampled after the latch.
// - rst mid-transaction: immediate return to IDLE, outputs 0, no done pulse. L2 is reset in the same cycle.
// - l2_addr[LINE_OFF-1:0] = 0 always.
// CONFIGURATION
// - L1ARB_DL1_PRIORITY_EN defined: DL1 always wins when both requesters are asserted; rr_last is ignored.
// - L1ARB_DL1_PRIORITY_EN undefined (default): round-robin as above.
// TESTING
// - Single IL1: il1_req=1, addr 0x0000_1234; ack at c+2, done at c+4.
//   -> l2_addr 0x0000_1230, l2_src 0, l2_we 0, il1_done pulses 1 cycle after done.
// - Tie twice: both req held from reset.
//   -> grant order IL1, DL1, IL1, DL1; never two consecutive grants to the same side.
// - Tie with macro defined: both req held -> DL1 granted every time, IL1 waits.
// - inv_busy=1 in IDLE for 5 cycles with il1_req=1 -> l2_req stays 0; l2_req rises 1 cycle after inv_busy falls.
// - Hang: l2_ack with no l2_done for TIMEOUT+1 cycles -> l2_timeout=1 and stays set until rst.
// - Reset in WAIT: rst=1 for 1 cycle -> next cycle state IDLE, l2_req=0, no dl1_done/il1_done pulse.

Source files
------------

// File: rtl/l1_l2_port_arbiter.sv
// l1_l2_port_arbiter
//   Shares the single L1->L2 refill/writeback port between the IL1 miss path
//   and the DL1 miss/writeback path. One transaction is in flight at a time:
//   IDLE (arbitrate) -> ISSUE (l2_req held until l2_ack) -> WAIT (until
//   l2_done, watchdog running) -> RESP (1-cycle done pulse to the owner).
//   New grants are held off while L2 back-invalidation (inv_busy) is active.
//
//   Build option: L1ARB_DL1_PRIORITY_EN
//     defined   -> DL1 always wins when both sides request
//     undefined -> round-robin; IL1 wins the first tie after reset
//
// Ports
//   clk_l1      L1 clock, all state on posedge
//   rst         synchronous reset, active-high
//   il1_req     IL1 refill request (level, held until il1_done)
//   il1_addr    IL1 miss address
//   il1_done    1-cycle pulse, IL1 transaction complete
//   dl1_req     DL1 request (level, held until dl1_done)
//   dl1_we      DL1 qualifier: 1 = writeback, 0 = refill
//   dl1_addr    DL1 address
//   dl1_done    1-cycle pulse, DL1 transaction complete
//   inv_busy    L2 back-invalidation active; blocks new grants only
//   l2_req      request to L2, held until l2_ack
//   l2_we       write/read qualifier for l2_req
//   l2_addr     line-aligned request address
//   l2_src      owner of current transaction: 0 = IL1, 1 = DL1
//   l2_ack      L2 accepted request (only looked at in ISSUE)
//   l2_done     L2 finished transaction (only looked at in WAIT)
//   l2_timeout  sticky hang flag, cleared only by rst
module l1_l2_port_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int LINE_OFF = 4,
   parameter int TIMEOUT  = 255
) (
   input  logic              clk_l1,
   input  logic              rst,
   input  logic              il1_req,
   input  logic [ADDR_W-1:0] il1_addr,
   output logic              il1_done,
   input  logic              dl1_req,
   input  logic              dl1_we,
   input  logic [ADDR_W-1:0] dl1_addr,
   output logic              dl1_done,
   input  logic              inv_busy,
   output logic              l2_req,
   output logic              l2_we,
   output logic [ADDR_W-1:0] l2_addr,
   output logic              l2_src,
   input  logic              l2_ack,
   input  logic              l2_done,
   output logic              l2_timeout
);

   localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << LINE_OFF) - 64'd1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t            state, state_nx;
   logic              src_q;     // 0 = IL1, 1 = DL1
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic              rr_last;   // side granted most recently
   logic [WD_W-1:0]   wd_q;
   logic              tout_q;
   logic              grant;
   logic              win_dl1;
   logic [ADDR_W-1:0] win_addr;

   // Winner among the asserted requests; only consumed when grant is high.
   always_comb begin
      win_dl1 = dl1_req;
      if (il1_req && dl1_req) begin
`ifdef L1ARB_DL1_PRIORITY_EN
         win_dl1 = 1'b1;
`else
         win_dl1 = ~rr_last;
`endif
      end
      win_addr = win_dl1 ? dl1_addr : il1_addr;
   end

   assign grant = (state == S_IDLE) && !inv_busy && (il1_req || dl1_req);

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (grant)   state_nx = S_ISSUE;
         // a same-cycle l2_done here is deliberately ignored
         S_ISSUE: if (l2_ack)  state_nx = S_WAIT;
         S_WAIT:  if (l2_done) state_nx = S_RESP;
         S_RESP:               state_nx = S_IDLE;
         default:              state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_l1) begin
      if (rst) begin
         state   <= S_IDLE;
         src_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         rr_last <= 1'b1;   // DL1, so IL1 wins the first tie
         wd_q    <= '0;
         tout_q  <= 1'b0;
      end else begin
         state <= state_nx;
         // request fields are captured once at grant and never re-sampled
         if (grant) begin
            src_q  <= win_dl1;
            we_q   <= win_dl1 & dl1_we;
            addr_q <= win_addr & ~OFF_MASK;
         end
         if (state == S_RESP) rr_last <= src_q;
         // watchdog only runs while waiting for l2_done; it parks at
         // TIMEOUT once the flag is raised so it cannot wrap
         if (state == S_WAIT) begin
            if (l2_done)
               wd_q <= '0;
            else if (wd_q == WD_W'(TIMEOUT))
               tout_q <= 1'b1;
            else
               wd_q <= wd_q + 1'b1;
         end
      end
   end

   assign l2_req     = (state == S_ISSUE);
   assign l2_we      = we_q;
   assign l2_addr    = addr_q;
   assign l2_src     = src_q;
   assign il1_done   = (state == S_RESP) && !src_q;
   assign dl1_done   = (state == S_RESP) &&  src_q;
   assign l2_timeout = tout_q;

endmodule

// File: tb/tb_l1_l2_port_arbiter.sv
// Bench for l1_l2_port_arbiter: the bench plays both L1 requesters and L2.
// The model works per transaction: it knows which requests are held, which
// side was granted last, and derives winner/address/qualifier from that.
module tb_l1_l2_port_arbiter;

   localparam int AW = 32;
   localparam int TO = 255;

   logic          clk_l1 = 1'b0;
   logic          rst;
   logic          il1_req, dl1_req, dl1_we, inv_busy, l2_ack, l2_done;
   logic [AW-1:0] il1_addr, dl1_addr, l2_addr;
   logic          il1_done, dl1_done, l2_req, l2_we, l2_src, l2_timeout;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;
   bit exp_last;  // model: 1 = DL1 was granted last

   always #5 clk_l1 = ~clk_l1;

   l1_l2_port_arbiter #(.ADDR_W(AW), .LINE_OFF(4), .TIMEOUT(TO)) dut (
      .clk_l1(clk_l1), .rst(rst),
      .il1_req(il1_req), .il1_addr(il1_addr), .il1_done(il1_done),
      .dl1_req(dl1_req), .dl1_we(dl1_we), .dl1_addr(dl1_addr), .dl1_done(dl1_done),
      .inv_busy(inv_busy),
      .l2_req(l2_req), .l2_we(l2_we), .l2_addr(l2_addr), .l2_src(l2_src),
      .l2_ack(l2_ack), .l2_done(l2_done), .l2_timeout(l2_timeout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Who should win given the request levels the bench is driving.
   function automatic bit pick_dl1(input bit i, input bit d);
      if (i && d) begin
`ifdef L1ARB_DL1_PRIORITY_EN
         return 1'b1;
`else
         return !exp_last;
`endif
      end
      return d;
   endfunction

   // One full transaction, entered and left at a negedge in IDLE.
   task automatic txn(input bit a_il1, input bit a_dl1, input int inv_n,
                      input bit keep, input bit drop_early);
      logic [31:0] exp_addr;
      bit          w, exp_we;
      int          n;
      if (a_il1 && !il1_req) begin il1_req = 1'b1; il1_addr = $urandom; end
      if (a_dl1 && !dl1_req) begin dl1_req = 1'b1; dl1_addr = $urandom; end
      dl1_we   = 1'($urandom_range(0, 1));
      inv_busy = (inv_n > 0);
      for (int i = 0; i < inv_n; i++) begin
         @(negedge clk_l1);
         chk("inv_gate_req", l2_req, 0);
      end
      inv_busy = 1'b0;
      w        = pick_dl1(il1_req, dl1_req);
      exp_addr = (w ? dl1_addr : il1_addr) & 32'hFFFF_FFF0;
      exp_we   = w & dl1_we;
      @(negedge clk_l1);
      chk("grant_req", l2_req, 1);
      chk("grant_src", l2_src, w);
      chk("grant_addr", l2_addr, exp_addr);
      chk("grant_we", l2_we, exp_we);
      // disturb the sources after grant; the latched request must not move
      if (w) begin dl1_addr = $urandom; dl1_we = ~dl1_we; end
      else il1_addr = $urandom;
      if (drop_early) begin if (w) dl1_req = 1'b0; else il1_req = 1'b0; end
      n = $urandom_range(0, 2);
      repeat (n) begin
         @(negedge clk_l1);
         chk("issue_hold_req", l2_req, 1);
         chk("issue_hold_addr", l2_addr, exp_addr);
         chk("issue_hold_we", l2_we, exp_we);
      end
      l2_ack  = 1'b1;
      l2_done = 1'($urandom_range(0, 1));  // done alongside ack is ignored
      @(negedge clk_l1);
      l2_ack  = 1'b0;
      l2_done = 1'b0;
      chk("wait_req_low", l2_req, 0);
      chk("wait_no_done", {il1_done, dl1_done}, 0);
      n = $urandom_range(0, 3);
      repeat (n) begin
         @(negedge clk_l1);
         chk("wait_no_done", {il1_done, dl1_done}, 0);
      end
      l2_done = 1'b1;
      @(negedge clk_l1);
      l2_done = 1'b0;
      chk("il1_done", il1_done, !w);
      chk("dl1_done", dl1_done, w);
      exp_last = w;
      if (!keep) begin if (w) dl1_req = 1'b0; else il1_req = 1'b0; end
      @(negedge clk_l1);
      chk("done_one_cycle", {il1_done, dl1_done}, 0);
      chk("idle_req_low", l2_req, 0);
   endtask

   initial begin
      rst = 1'b1; il1_req = 0; dl1_req = 0; dl1_we = 0; inv_busy = 0;
      l2_ack = 0; l2_done = 0; il1_addr = '0; dl1_addr = '0;
      exp_last = 1'b1;
      repeat (2) @(negedge clk_l1);
      rst = 1'b0;
      chk("rst_l2_req", l2_req, 0);
      chk("rst_l2_we", l2_we, 0);
      chk("rst_l2_addr", l2_addr, 0);
      chk("rst_l2_src", l2_src, 0);
      chk("rst_done", {il1_done, dl1_done}, 0);
      chk("rst_timeout", l2_timeout, 0);

      // tie held from reset
      il1_req = 1'b1; il1_addr = $urandom;
      dl1_req = 1'b1; dl1_addr = $urandom;
      for (int i = 0; i < 4; i++) txn(1, 1, 0, 1, 0);
      il1_req = 1'b0; dl1_req = 1'b0;
      @(negedge clk_l1);
      chk("tie_end_idle", l2_req, 0);

      // single IL1 with a fixed offset address
      il1_req = 1'b1; il1_addr = 32'h0000_1234;
      txn(1, 0, 0, 0, 0);

      // inv_busy gating for 5 cycles
      il1_req = 1'b1; il1_addr = $urandom;
      txn(1, 0, 5, 0, 0);

      // randomized traffic
      for (int i = 0; i < 30; i++) begin
         bit ai, ad;
         ai = 1'($urandom_range(0, 1));
         ad = 1'($urandom_range(0, 1));
         if (!ai && !ad && !il1_req && !dl1_req) ai = 1'b1;
         txn(ai, ad, $urandom_range(0, 2), ($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 1)));
      end
      il1_req = 1'b0; dl1_req = 1'b0;
      @(negedge clk_l1);
      chk("rand_end_idle", l2_req, 0);

      // hung L2: ack, then no done
      il1_req = 1'b1; il1_addr = $urandom;
      @(negedge clk_l1);
      chk("hang_req", l2_req, 1);
      l2_ack = 1'b1;
      @(negedge clk_l1);
      l2_ack = 1'b0;
      repeat (TO) @(negedge clk_l1);
      chk("hang_not_yet", l2_timeout, 0);
      @(negedge clk_l1);
      chk("hang_timeout", l2_timeout, 1);
      repeat (3) @(negedge clk_l1);
      chk("hang_stay_wait", {l2_req, il1_done, dl1_done}, 0);
      l2_done = 1'b1;
      @(negedge clk_l1);
      l2_done = 1'b0;
      chk("hang_late_done", il1_done, 1);
      exp_last = 1'b0;
      il1_req = 1'b0;
      @(negedge clk_l1);
      chk("hang_sticky", l2_timeout, 1);

      // reset while in WAIT
      dl1_req = 1'b1; dl1_addr = $urandom;
      @(negedge clk_l1);
      chk("rstw_req", l2_req, 1);
      chk("rstw_src", l2_src, 1);
      l2_ack = 1'b1;
      @(negedge clk_l1);
      l2_ack = 1'b0;
      @(negedge clk_l1);
      rst = 1'b1; dl1_req = 1'b0;
      @(negedge clk_l1);
      rst = 1'b0;
      exp_last = 1'b1;
      chk("rstw_l2_req", l2_req, 0);
      chk("rstw_done", {il1_done, dl1_done}, 0);
      chk("rstw_src0", l2_src, 0);
      chk("rstw_addr0", l2_addr, 0);
      chk("rstw_timeout_clr", l2_timeout, 0);
      @(negedge clk_l1);
      chk("rstw_no_pulse", {il1_done, dl1_done, l2_req}, 0);

      // tie again after reset: round-robin restarts with IL1
      il1_req = 1'b1; il1_addr = $urandom;
      dl1_req = 1'b1; dl1_addr = $urandom;
      for (int i = 0; i < 2; i++) txn(1, 1, 0, 1, 0);
      il1_req = 1'b0; dl1_req = 1'b0;
      @(negedge clk_l1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
